// File: rtl/fir_meas_pkg.sv
// Shared types and helpers for the tone meter: crossing/measurement states
// and the saturating magnitude used for peak tracking.
package fir_meas_pkg;

   localparam int FM_DW = 13;

   typedef enum logic [1:0] {
      CS_UNK = 2'd0,
      CS_NEG = 2'd1,
      CS_POS = 2'd2
   } cross_state_e;

   typedef enum logic {
      MS_IDLE  = 1'b0,
      MS_ACCUM = 1'b1
   } meas_state_e;

   // Magnitude of a sign-extended sample, clipped so the most negative code
   // still fits in the unsigned peak register.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] s,
                                           input logic [31:0]        max_mag);
      logic [31:0] mag;
      mag = (s < 0) ? 32'(-s) : 32'(s);
      return (mag > max_mag) ? max_mag : mag;
   endfunction

endpackage

// File: rtl/fir_zero_cross_hyst.sv
// Hysteretic zero-crossing detector; rise is combinational on the accepted
// sample that moves the state from NEG to POS.
//
//   state  | meaning
//   -------+-------------------------------------------------
//   CS_UNK | polarity not yet known, never emits a rise
//   CS_NEG | last decisive sample was <= -HYST
//   CS_POS | last decisive sample was >= +HYST
module fir_zero_cross_hyst
   import fir_meas_pkg::*;
#(
   parameter int DW   = FM_DW,
   parameter int HYST = 64
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic signed [DW-1:0] din,
   input  logic                 valid,
   output logic                 rise
);

   localparam logic signed [DW-1:0] TH_HI = DW'(HYST);
   localparam logic signed [DW-1:0] TH_LO = DW'(-HYST);

   cross_state_e state_q, state_d;
   logic         ge_hi, le_lo;

   assign ge_hi = (din >= TH_HI);
   assign le_lo = (din <= TH_LO);

   always_comb begin
      state_d = state_q;
      rise    = 1'b0;
      if (valid) begin
         case (state_q)
            CS_UNK: begin
               if (ge_hi)      state_d = CS_POS;
               else if (le_lo) state_d = CS_NEG;
            end
            CS_NEG: begin
               if (ge_hi) begin
                  state_d = CS_POS;
                  rise    = 1'b1;
               end
            end
            CS_POS: begin
               if (le_lo) state_d = CS_NEG;
            end
            default: state_d = CS_UNK;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) state_q <= CS_UNK;
      else            state_q <= state_d;
   end

endmodule

// File: rtl/fir_tone_meter.sv
// Measures the averaged period (in accepted samples) and peak magnitude of
// the tone leaving the FIR, over continuous windows of 2^AVG_LOG2 periods.
//
//   state    | meaning
//   ---------+----------------------------------------------------
//   MS_IDLE  | waiting for the first rise to open a window
//   MS_ACCUM | counting samples per period, summing periods, peak
module fir_tone_meter
   import fir_meas_pkg::*;
#(
   parameter int DW       = FM_DW,
   parameter int HYST     = 64,
   parameter int AVG_LOG2 = 4,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 65535
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic signed [DW-1:0] fir_din,
   input  logic                 fir_valid,
   output logic [CNT_W-1:0]     period_avg,
   output logic [DW-2:0]        amp_peak,
   output logic                 meas_valid,
   output logic                 locked
);

   localparam int SW = CNT_W + AVG_LOG2;
   localparam int NW = AVG_LOG2 + 1;
   localparam int AW = DW - 1;
   localparam logic [NW-1:0]    N_FULL  = NW'(1 << AVG_LOG2);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [31:0]      ABS_MAX = 32'((1 << (DW - 1)) - 1);

   meas_state_e      mstate_q, mstate_d;
   logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
   logic [SW-1:0]    sum_q, sum_d;
   logic [AW-1:0]    peak_q, peak_d;
   logic [NW-1:0]    n_q, n_d;
   logic [CNT_W-1:0] period_avg_q, period_avg_d;
   logic [AW-1:0]    amp_peak_q, amp_peak_d;
   logic             meas_valid_q, meas_valid_d;
   logic             locked_q, locked_d;

   logic             rise;
   logic [AW-1:0]    abs_s, peak_max;
   logic [SW-1:0]    sum_new;
   logic [NW-1:0]    n_inc;

   fir_zero_cross_hyst #(
      .DW   (DW),
      .HYST (HYST)
   ) u_zc (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .din       (fir_din),
      .valid     (fir_valid),
      .rise      (rise)
   );

   assign abs_s    = AW'(sat_abs(32'(fir_din), ABS_MAX));
   assign peak_max = (abs_s > peak_q) ? abs_s : peak_q;
   assign sum_new  = sum_q + SW'(per_cnt_q) + SW'(1);
   assign n_inc    = n_q + 1'b1;

   always_comb begin
      mstate_d     = mstate_q;
      per_cnt_d    = per_cnt_q;
      sum_d        = sum_q;
      peak_d       = peak_q;
      n_d          = n_q;
      period_avg_d = period_avg_q;
      amp_peak_d   = amp_peak_q;
      meas_valid_d = 1'b0;
      locked_d     = locked_q;
      if (fir_valid) begin
         case (mstate_q)
            MS_IDLE: begin
               if (rise) begin
                  mstate_d  = MS_ACCUM;
                  per_cnt_d = '0;
                  sum_d     = '0;
                  peak_d    = abs_s;
                  n_d       = '0;
               end
            end
            MS_ACCUM: begin
               if (rise) begin
                  per_cnt_d = '0;
                  if (n_inc == N_FULL) begin
                     // The completing rise also opens the next window.
                     period_avg_d = CNT_W'(sum_new >> AVG_LOG2);
                     amp_peak_d   = peak_max;
                     meas_valid_d = 1'b1;
                     locked_d     = 1'b1;
                     sum_d        = '0;
                     peak_d       = '0;
                     n_d          = '0;
                  end else begin
                     sum_d  = sum_new;
                     peak_d = peak_max;
                     n_d    = n_inc;
                  end
               end else if (per_cnt_q == TO_LAST) begin
                  mstate_d  = MS_IDLE;
                  locked_d  = 1'b0;
                  per_cnt_d = '0;
                  sum_d     = '0;
                  peak_d    = '0;
                  n_d       = '0;
               end else begin
                  per_cnt_d = per_cnt_q + 1'b1;
                  peak_d    = peak_max;
               end
            end
            default: mstate_d = MS_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         mstate_q     <= MS_IDLE;
         per_cnt_q    <= '0;
         sum_q        <= '0;
         peak_q       <= '0;
         n_q          <= '0;
         period_avg_q <= '0;
         amp_peak_q   <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
      end else begin
         mstate_q     <= mstate_d;
         per_cnt_q    <= per_cnt_d;
         sum_q        <= sum_d;
         peak_q       <= peak_d;
         n_q          <= n_d;
         period_avg_q <= period_avg_d;
         amp_peak_q   <= amp_peak_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
      end
   end

   assign period_avg = period_avg_q;
   assign amp_peak   = amp_peak_q;
   assign meas_valid = meas_valid_q;
   assign locked     = locked_q;

endmodule

// File: tb/tb_fir_tone_meter.sv
// Directed bench for fir_tone_meter; TIMEOUT is shortened to 1000 so the
// noise and loss-of-lock scenarios stay short.
module tb_fir_tone_meter;

   localparam int DW = 13;
   localparam int TO = 1000;

   logic                 clk_sys;
   logic                 rst_n;
   logic signed [DW-1:0] fir_din;
   logic                 fir_valid;
   logic [15:0]          period_avg;
   logic [DW-2:0]        amp_peak;
   logic                 meas_valid;
   logic                 locked;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int mv_cnt = 0;
   int mv_last = 0;
   int mv_gap = 0;
   int base;

   fir_tone_meter #(
      .DW       (DW),
      .HYST     (64),
      .AVG_LOG2 (4),
      .CNT_W    (16),
      .TIMEOUT  (TO)
   ) dut (
      .sys_clk    (clk_sys),
      .sys_rst_n  (rst_n),
      .fir_din    (fir_din),
      .fir_valid  (fir_valid),
      .period_avg (period_avg),
      .amp_peak   (amp_peak),
      .meas_valid (meas_valid),
      .locked     (locked)
   );

   initial begin
      clk_sys = 1'b0;
      forever #5 clk_sys = ~clk_sys;
   end

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (rst_n && meas_valid) begin
         mv_cnt  <= mv_cnt + 1;
         mv_gap  <= cyc - mv_last;
         mv_last <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int v, input logic vld);
      fir_din   = DW'(v);
      fir_valid = vld;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic half(input int v, input int n, input bit tog);
      for (int i = 0; i < n; i++) begin
         step(v, 1'b1);
         if (tog) step(-v, 1'b0);
      end
   endtask

   task automatic run_square(input int nper, input int amp, input bit tog);
      for (int p = 0; p < nper; p++) begin
         half(-amp, 50, tog);
         half(amp, 50, tog);
      end
   endtask

   task automatic do_reset();
      fir_valid = 1'b0;
      fir_din   = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk_sys);
      #2 rst_n = 1'b1;
      @(posedge clk_sys);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      fir_valid = 1'b0;
      fir_din   = '0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("rst_period", 32'(period_avg), 0);
      chk("rst_amp", 32'(amp_peak), 0);
      chk("rst_mvalid", 32'(meas_valid), 0);
      chk("rst_locked", 32'(locked), 0);
      #1 rst_n = 1'b1;
      @(posedge clk_sys);
      #1;

      // Square, valid every cycle, starts negative
      base = mv_cnt;
      for (int p = 0; p < 20; p++) begin
         half(-1000, 50, 1'b0);
         step(1000, 1'b1);
         if (p == 15) begin
            chk("t1_pre_mvalid", 32'(meas_valid), 0);
            chk("t1_pre_locked", 32'(locked), 0);
            chk("t1_pre_period", 32'(period_avg), 0);
         end
         if (p == 16) begin
            chk("t1_mvalid", 32'(meas_valid), 1);
            chk("t1_period", 32'(period_avg), 100);
            chk("t1_amp", 32'(amp_peak), 1000);
            chk("t1_locked", 32'(locked), 1);
         end
         for (int i = 0; i < 49; i++) begin
            step(1000, 1'b1);
            if (p == 16 && i == 0) chk("t1_pulse_len", 32'(meas_valid), 0);
         end
      end
      chk("t1_meas_count", 32'(mv_cnt - base), 1);
      chk("t1_period_hold", 32'(period_avg), 100);

      // Same square with fir_valid toggling every cycle
      do_reset();
      base = mv_cnt;
      run_square(34, 1000, 1'b1);
      chk("t2_meas_count", 32'(mv_cnt - base), 2);
      chk("t2_gap", 32'(mv_gap), 3200);
      chk("t2_period", 32'(period_avg), 100);
      chk("t2_locked", 32'(locked), 1);

      // Noise inside the hysteresis band, then a real tone
      do_reset();
      base = mv_cnt;
      for (int i = 0; i < 3000; i++) step((i % 2 == 0) ? 63 : -63, 1'b1);
      chk("t3_noise_count", 32'(mv_cnt - base), 0);
      chk("t3_noise_locked", 32'(locked), 0);
      run_square(18, 1000, 1'b0);
      chk("t3_meas_count", 32'(mv_cnt - base), 1);
      chk("t3_locked", 32'(locked), 1);
      chk("t3_period", 32'(period_avg), 100);

      // Loss of lock: stop right on a rise, then hold zero
      half(-1000, 50, 1'b0);
      step(1000, 1'b1);
      base = mv_cnt;
      for (int i = 0; i < TO - 1; i++) step(0, 1'b1);
      chk("t4_locked_before", 32'(locked), 1);
      step(0, 1'b1);
      chk("t4_locked_drop", 32'(locked), 0);
      chk("t4_period_hold", 32'(period_avg), 100);
      chk("t4_amp_hold", 32'(amp_peak), 1000);
      run_square(16, 1000, 1'b0);
      chk("t4_relock_early", 32'(locked), 0);
      chk("t4_count_early", 32'(mv_cnt - base), 0);
      half(-1000, 50, 1'b0);
      step(1000, 1'b1);
      chk("t4_relock_mvalid", 32'(meas_valid), 1);
      chk("t4_relock", 32'(locked), 1);

      // Full-scale amplitude with one most-negative sample
      do_reset();
      run_square(8, 4095, 1'b0);
      half(-4095, 49, 1'b0);
      step(-4096, 1'b1);
      half(4095, 50, 1'b0);
      run_square(8, 4095, 1'b0);
      chk("t5_full_amp", 32'(amp_peak), 4095);
      chk("t5_full_period", 32'(period_avg), 100);

      do_reset();
      run_square(8, 2000, 1'b0);
      half(-2000, 49, 1'b0);
      step(-4096, 1'b1);
      half(2000, 50, 1'b0);
      run_square(8, 2000, 1'b0);
      chk("t5_sat_amp", 32'(amp_peak), 4095);
      chk("t5_sat_locked", 32'(locked), 1);

      // Asynchronous reset mid-window
      run_square(5, 2000, 1'b0);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_rst_period", 32'(period_avg), 0);
      chk("t6_rst_amp", 32'(amp_peak), 0);
      chk("t6_rst_locked", 32'(locked), 0);
      chk("t6_rst_mvalid", 32'(meas_valid), 0);
      repeat (2) @(posedge clk_sys);
      #2 rst_n = 1'b1;
      base = mv_cnt;
      run_square(16, 1500, 1'b0);
      chk("t6_early_locked", 32'(locked), 0);
      chk("t6_early_count", 32'(mv_cnt - base), 0);
      half(-1500, 50, 1'b0);
      step(1500, 1'b1);
      chk("t6_mvalid", 32'(meas_valid), 1);
      chk("t6_period", 32'(period_avg), 100);
      chk("t6_amp", 32'(amp_peak), 1500);
      chk("t6_locked", 32'(locked), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_tone_meter.md
Name: fir_tone_meter

Overview:
- Sits directly downstream of the low-pass FIR stage and consumes its signed 13-bit output and the output-valid strobe.
- Detects rising zero crossings with hysteresis to measure the period of the surviving tone, in samples, averaged over 2^AVG_LOG2 periods.
- Tracks peak absolute amplitude over the same window.
- Gives on-board proof that the 5 MHz component is removed and the 1 MHz tone passes: 100 samples/period at 100 MHz.

Parameters:
- DW, 13, input sample width (signed two's complement).
- HYST, 64, hysteresis threshold magnitude in LSBs, positive, < 2^(DW-1).
- AVG_LOG2, 4, log2 of the number of periods averaged per measurement (16).
- CNT_W, 16, width of the period counter and of period_avg.
- TIMEOUT, 65535, valid samples without a rising edge before the lock is dropped; must be ≤ 2^CNT_W-1.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst_n  in  1  asynchronous active-low reset.
- fir_din  in  DW  signed filtered sample.
- fir_valid  in  1  fir_din qualifier; one sample per high cycle.
- period_avg  out  CNT_W  averaged period in samples, truncated.
- amp_peak  out  DW-1  max |sample| in the window, unsigned.
- meas_valid  out  1  one-cycle pulse when period_avg/amp_peak update.
- locked  out  1  high after the first completed measurement.

Behaviour:
- Reset, asynchronous, active-low. Clocked by sys_clk, asynchronous active-low reset on sys_rst_n. All outputs and state clear to 0. Crossing state goes to UNK, measurement FSM to IDLE. Reset mid-window discards all partial results.
- Gating. Nothing advances on cycles with fir_valid low. All counting is in accepted samples, not clocks.
- Crossing FSM (UNK/NEG/POS), per accepted sample s:
  - UNK: s ≥ HYST → POS; s ≤ -HYST → NEG; else stay. No edge is ever emitted from UNK.
  - NEG: s ≥ HYST → POS and emit a rise event on this sample.
  - POS: s ≤ -HYST → NEG.
  - Samples inside (-HYST, HYST) never change state.
- Measurement FSM:
  - IDLE: on rise → clear per_cnt, sum, peak and n; go to ACCUM. locked is unchanged.
  - ACCUM, accepted sample without rise: per_cnt += 1.
  - ACCUM, rise: period = per_cnt + 1; sum += period; n += 1; per_cnt ← 0.
  - Window complete, when n reaches 2^AVG_LOG2 on a rise:
    - period_avg ← (sum incl. current period) >> AVG_LOG2;
    - amp_peak ← peak incl. current sample;
    - meas_valid = 1 in the next cycle; locked ← 1;
    - sum, peak and n clear, and the same rise starts the next window, so windows are continuous.
  - Timeout: per_cnt reaches TIMEOUT-1 on an accepted sample without rise → go to IDLE, locked ← 0, clear the accumulators. period_avg and amp_peak hold their last values.
- Peak. On every accepted sample in ACCUM, including the starting rise sample, peak = max(peak, |s|).
  - |-2^(DW-1)| saturates to 2^(DW-1)-1.
  - The comparison uses the new sample in the same cycle it is accepted.
- Widths and latency:
  - sum is CNT_W+AVG_LOG2 bits and cannot overflow, because per_cnt is bounded by TIMEOUT.
  - All outputs are registered. Latency from the completing rise sample to meas_valid is 1 cycle.
  - period_avg and amp_peak change only together with meas_valid and hold otherwise.

Decomposition:
- Package fir_meas_pkg holds:
  - the DW default;
  - the crossing-state enum (UNK, NEG, POS);
  - the measurement-state enum (IDLE, ACCUM);
  - the saturating-abs function.
- Sub-module fir_zero_cross_hyst contains the crossing FSM. Its ports are sys_clk, sys_rst_n, din, valid and a registered-free rise output, which is combinational on the accepted sample.
- fir_tone_meter instantiates fir_zero_cross_hyst and holds the counters, accumulator, peak and measurement FSM.

Test Plan:
- Square input, valid every cycle: 50×(+1000) then 50×(-1000), repeated 20 cycles, start negative → first meas_valid exactly 1 cycle after the 17th rise sample; period_avg=100, amp_peak=1000, locked=1.
- Same square with fir_valid toggling 1/0 every cycle → period_avg=100 (samples, not clocks); meas_valid spacing 3200 clocks.
- Noise only, values alternating +63/-63 (inside HYST=64) for 70000 samples → no meas_valid, locked stays 0. Then the square from test 1 → locks normally.
- Lock, then hold input at 0 for 65535 accepted samples → locked falls on the 65535th; period_avg holds 100. The square then resumes → relock after 16 full periods.
- Square amplitude ±4095 with one sample of -4096 mid-window → amp_peak=4095, no overflow.
- Assert sys_rst_n low asynchronously mid-window, then release → all outputs 0 immediately. The next valid measurement needs the first rise plus 16 full periods.
